// File: rtl/triggered_acquisition_bram_if.sv
// Stream and readout bundle for triggered_acquisition_bram.
//   master: ADC/bridge side -- drives axiValid, axiData, readAddress, readSelect;
//           receives readData.
//   slave : acquisition block -- receives the stream and read request,
//           drives readData.
// Parameters mirror the acquisition block so the derived widths agree.
interface triggered_acquisition_bram_if #(
  parameter int ACQUISITION_BUFFER_CAPACITY = 1024,
  parameter int AXI_CHANNEL_COUNT           = 2,
  parameter int AXI_SAMPLE_WIDTH            = 16,
  parameter int AXI_SAMPLES_PER_CLOCK       = 2
);
  localparam int DW = AXI_CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK * AXI_SAMPLE_WIDTH;
  localparam int AW = $clog2(ACQUISITION_BUFFER_CAPACITY / AXI_SAMPLES_PER_CLOCK);
  localparam int SW = (DW / AXI_SAMPLE_WIDTH > 1) ? $clog2(DW / AXI_SAMPLE_WIDTH) : 1;

  logic                        axiValid;
  logic [DW-1:0]               axiData;
  logic [AW-1:0]               readAddress;
  logic [SW-1:0]               readSelect;
  logic [AXI_SAMPLE_WIDTH-1:0] readData;

  modport master (
    output axiValid, axiData, readAddress, readSelect,
    input  readData
  );

  modport slave (
    input  axiValid, axiData, readAddress, readSelect,
    output readData
  );
endinterface

// File: rtl/triggered_acquisition_bram.sv
// Triggered acquisition buffer.
// Captures AXI ADC sample words into a circular block RAM. An arm pulse starts
// a record: PREFILL collects the pre-trigger window, ARMED keeps the ring
// rolling until a trigger, POST fills the remaining DEPTH-pre words, DONE
// freezes the record. The readout port addresses the record oldest-first.
// Ports:
//   adcClk, adcReset   clock and asynchronous active-high reset
//   axi (slave)        axiValid/axiData stream in; readAddress/readSelect in,
//                      readData out (3-cycle pipelined readout)
//   triggerIn          level trigger, rising edge is the event
//   armStrobe          start a record (latches preTriggerWords)
//   abortStrobe        return to IDLE, memory kept; beats arm
//   forceTrigger       software trigger
//   preTriggerWords    pre-trigger beats
//   state, done        0 IDLE, 1 PREFILL, 2 ARMED, 3 POST, 4 DONE
//   triggerAddress     physical address of the first post-trigger beat
//   writeAddress       current physical write pointer
module triggered_acquisition_bram #(
  parameter int ACQUISITION_BUFFER_CAPACITY = 1024,
  parameter int AXI_CHANNEL_COUNT           = 2,
  parameter int AXI_SAMPLE_WIDTH            = 16,
  parameter int AXI_SAMPLES_PER_CLOCK       = 2,
  localparam int DW = AXI_CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK * AXI_SAMPLE_WIDTH,
  localparam int AW = $clog2(ACQUISITION_BUFFER_CAPACITY / AXI_SAMPLES_PER_CLOCK),
  localparam int SW = (DW / AXI_SAMPLE_WIDTH > 1) ? $clog2(DW / AXI_SAMPLE_WIDTH) : 1
) (
  input  logic                          adcClk,
  input  logic                          adcReset,
  triggered_acquisition_bram_if.slave   axi,
  input  logic                          triggerIn,
  input  logic                          armStrobe,
  input  logic                          abortStrobe,
  input  logic                          forceTrigger,
  input  logic [AW-1:0]                 preTriggerWords,
  output logic [2:0]                    state,
  output logic                          done,
  output logic [AW-1:0]                 triggerAddress,
  output logic [AW-1:0]                 writeAddress
);
  localparam int DEPTH      = 1 << AW;
  localparam int LANES      = DW / AXI_SAMPLE_WIDTH;
  localparam int LANE_SLOTS = 1 << SW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Capacity must split into a power-of-two number of words (at least two).
  generate
    if ((ACQUISITION_BUFFER_CAPACITY % AXI_SAMPLES_PER_CLOCK) != 0 ||
        (ACQUISITION_BUFFER_CAPACITY / AXI_SAMPLES_PER_CLOCK) != DEPTH ||
        DEPTH < 2) begin : gBadCapacity
      $error("ACQUISITION_BUFFER_CAPACITY / AXI_SAMPLES_PER_CLOCK must be an integer power of two");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } acqState_t;

  acqState_t     stateReg, stateNext;
  logic [AW-1:0] wpReg, wpNext;
  logic [AW:0]   cntReg, cntNext;
  logic [AW-1:0] preReg, preNext;
  logic [AW:0]   postReg, postNext;       // DEPTH - pre, needs AW+1 bits for pre = 0
  logic [AW-1:0] trigAddrReg, trigAddrNext;
  logic          triggerInD;
  logic          writeEn;
  logic          trig;
  logic [AW:0]   cntInc;

  // ---------------- control state register ----------------
  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      stateReg    <= IDLE;
      wpReg       <= '0;
      cntReg      <= '0;
      preReg      <= '0;
      postReg     <= '0;
      trigAddrReg <= '0;
      triggerInD  <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      wpReg       <= wpNext;
      cntReg      <= cntNext;
      preReg      <= preNext;
      postReg     <= postNext;
      trigAddrReg <= trigAddrNext;
      triggerInD  <= triggerIn;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    stateNext    = stateReg;
    wpNext       = wpReg;
    cntNext      = cntReg;
    preNext      = preReg;
    postNext     = postReg;
    trigAddrNext = trigAddrReg;
    writeEn      = 1'b0;
    trig         = (triggerIn & ~triggerInD) | forceTrigger;
    cntInc       = cntReg + (AW + 1)'(1);

    if (abortStrobe) begin
      stateNext = IDLE;
    end else if (armStrobe) begin
      // Arm restarts the record; any beat or trigger edge this cycle is dropped.
      wpNext    = '0;
      cntNext   = '0;
      preNext   = preTriggerWords;
      postNext  = DEPTH_C - {1'b0, preTriggerWords};
      stateNext = (preTriggerWords == '0) ? ARMED : PREFILL;
    end else begin
      writeEn = axi.axiValid &&
                (stateReg == PREFILL || stateReg == ARMED || stateReg == POST);
      if (writeEn) wpNext = wpReg + AW'(1);

      case (stateReg)
        PREFILL: begin
          if (axi.axiValid) begin
            if (cntInc == {1'b0, preReg}) begin
              stateNext = ARMED;
              cntNext   = '0;
            end else begin
              cntNext = cntInc;
            end
          end
        end
        ARMED: begin
          if (trig) begin
            // A beat arriving with the trigger is the first post-trigger beat.
            trigAddrNext = wpReg;
            if (axi.axiValid) begin
              cntNext   = (AW + 1)'(1);
              stateNext = (postReg == (AW + 1)'(1)) ? DONE : POST;
            end else begin
              cntNext   = '0;
              stateNext = POST;
            end
          end
        end
        POST: begin
          if (axi.axiValid) begin
            cntNext = cntInc;
            if (cntInc == postReg) stateNext = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign state          = stateReg;
  assign done           = (stateReg == DONE);
  assign triggerAddress = trigAddrReg;
  assign writeAddress   = wpReg;

  // ---------------- sample RAM and readout pipeline ----------------
  logic [DW-1:0]               dpram [DEPTH];
  logic [DW-1:0]               ramWord;
  logic [AW-1:0]               physReg;
  logic [SW-1:0]               selS1;
  logic [SW-1:0]               selS2;
  logic [AXI_SAMPLE_WIDTH-1:0] readDataReg;
  logic [AXI_SAMPLE_WIDTH-1:0] laneWord [LANE_SLOTS];

  // Read-first single-port-write / single-port-read RAM, no reset on the array.
  always_ff @(posedge adcClk) begin
    if (writeEn) dpram[wpReg] <= axi.axiData;
    ramWord <= dpram[physReg];
  end

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      physReg     <= '0;
      selS1       <= '0;
      selS2       <= '0;
      readDataReg <= '0;
    end else begin
      // Logical index 0 is the oldest beat: triggerAddress - pre.
      physReg     <= trigAddrReg - preReg + axi.readAddress;
      selS1       <= axi.readSelect;
      selS2       <= selS1;
      readDataReg <= laneWord[selS2];
    end
  end

  // Lane slots beyond the word's sample count read as zero.
  generate
    for (genvar gi = 0; gi < LANE_SLOTS; gi++) begin : gLane
      if (gi < LANES) begin : gReal
        assign laneWord[gi] = ramWord[gi*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH];
      end else begin : gPad
        assign laneWord[gi] = '0;
      end
    end
  endgenerate

  assign axi.readData = readDataReg;
endmodule

// File: tb/tb_triggered_acquisition_bram.sv
// Directed bench for triggered_acquisition_bram with a 32-word ring
// (capacity 64, two samples per clock, two channels, 16-bit samples).
// Beat k carries sample value k*4+lane in each of its four lanes.
module tb_triggered_acquisition_bram;
  localparam int CAP = 64;
  localparam int CH  = 2;
  localparam int SWD = 16;
  localparam int SPC = 2;
  localparam int DW  = CH * SPC * SWD;
  localparam int AW  = 5;
  localparam int SW  = 2;

  logic          adcClk;
  logic          adcReset;
  logic          triggerIn;
  logic          armStrobe;
  logic          abortStrobe;
  logic          forceTrigger;
  logic [AW-1:0] preTriggerWords;
  logic [2:0]    state;
  logic          done;
  logic [AW-1:0] triggerAddress;
  logic [AW-1:0] writeAddress;

  int total = 0;
  int bad   = 0;

  triggered_acquisition_bram_if #(
    .ACQUISITION_BUFFER_CAPACITY(CAP),
    .AXI_CHANNEL_COUNT(CH),
    .AXI_SAMPLE_WIDTH(SWD),
    .AXI_SAMPLES_PER_CLOCK(SPC)
  ) bus ();

  triggered_acquisition_bram #(
    .ACQUISITION_BUFFER_CAPACITY(CAP),
    .AXI_CHANNEL_COUNT(CH),
    .AXI_SAMPLE_WIDTH(SWD),
    .AXI_SAMPLES_PER_CLOCK(SPC)
  ) dut (
    .adcClk(adcClk),
    .adcReset(adcReset),
    .axi(bus),
    .triggerIn(triggerIn),
    .armStrobe(armStrobe),
    .abortStrobe(abortStrobe),
    .forceTrigger(forceTrigger),
    .preTriggerWords(preTriggerWords),
    .state(state),
    .done(done),
    .triggerAddress(triggerAddress),
    .writeAddress(writeAddress)
  );

  initial adcClk = 1'b0;
  always #5 adcClk = ~adcClk;

  function automatic logic [DW-1:0] mkBeat(input int k);
    logic [DW-1:0] r;
    for (int l = 0; l < 4; l++) r[l*SWD +: SWD] = 16'(k * 4 + l);
    return r;
  endfunction

  function automatic logic [15:0] expSample(input int k, input int sel);
    return 16'(k * 4 + sel);
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge adcClk);
    #1;
  endtask

  task automatic sendBeat(input int k);
    bus.axiValid = 1'b1;
    bus.axiData  = mkBeat(k);
    step();
    bus.axiValid = 1'b0;
    bus.axiData  = '1;
  endtask

  task automatic arm(input int pre);
    preTriggerWords = AW'(pre);
    armStrobe = 1'b1;
    step();
    armStrobe = 1'b0;
  endtask

  task automatic force_trig();
    forceTrigger = 1'b1;
    step();
    forceTrigger = 1'b0;
  endtask

  task automatic readSample(input int addr, input int sel, output logic [15:0] v);
    bus.readAddress = AW'(addr);
    bus.readSelect  = SW'(sel);
    repeat (3) step();
    v = bus.readData;
  endtask

  task automatic test_reset();
    adcReset = 1'b1;
    repeat (2) step();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state actual=%0d expected=0", state); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done actual=%0b expected=0", done); end
    total++; if (writeAddress !== 5'd0) begin bad++; $display("FAIL reset_wp actual=%0d expected=0", writeAddress); end
    total++; if (triggerAddress !== 5'd0) begin bad++; $display("FAIL reset_trigaddr actual=%0d expected=0", triggerAddress); end
    total++; if (bus.readData !== 16'd0) begin bad++; $display("FAIL reset_readdata actual=%0d expected=0", bus.readData); end
    adcReset = 1'b0;
    step();
    $display("test_reset: reset values checked");
  endtask

  task automatic test_pre8();
    logic [15:0] v;
    arm(8);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL pre8_prefill actual=%0d expected=1", state); end
    for (int k = 0; k < 8; k++) sendBeat(k);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL pre8_armed actual=%0d expected=2", state); end
    for (int k = 8; k <= 20; k++) sendBeat(k);
    force_trig();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL pre8_post actual=%0d expected=3", state); end
    total++; if (triggerAddress !== 5'd21) begin bad++; $display("FAIL pre8_trigaddr actual=%0d expected=21", triggerAddress); end
    for (int k = 21; k <= 43; k++) sendBeat(k);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL pre8_still_post actual=%0d expected=3", state); end
    sendBeat(44);
    total++; if (state !== 3'd4 || done !== 1'b1) begin bad++; $display("FAIL pre8_done actual=%0d/%0b expected=4/1", state, done); end
    total++; if (writeAddress !== 5'd13) begin bad++; $display("FAIL pre8_wp actual=%0d expected=13", writeAddress); end
    sendBeat(999);
    total++; if (writeAddress !== 5'd13) begin bad++; $display("FAIL pre8_done_nowrite actual=%0d expected=13", writeAddress); end
    readSample(0, 0, v);
    total++; if (v !== expSample(13, 0)) begin bad++; $display("FAIL pre8_rd0 actual=%0d expected=%0d", v, expSample(13, 0)); end
    for (int s = 0; s < 4; s++) begin
      readSample(8, s, v);
      total++; if (v !== expSample(21, s)) begin bad++; $display("FAIL pre8_rd8_lane%0d actual=%0d expected=%0d", s, v, expSample(21, s)); end
    end
    readSample(31, 3, v);
    total++; if (v !== expSample(44, 3)) begin bad++; $display("FAIL pre8_rd31 actual=%0d expected=%0d", v, expSample(44, 3)); end
    $display("test_pre8: record read back");
  endtask

  task automatic test_reset_mid_post();
    arm(0);
    force_trig();
    sendBeat(1);
    sendBeat(2);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL rstpost_pre actual=%0d expected=3", state); end
    #2;
    adcReset = 1'b1;
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rstpost_state actual=%0d expected=0", state); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstpost_done actual=%0b expected=0", done); end
    total++; if (writeAddress !== 5'd0) begin bad++; $display("FAIL rstpost_wp actual=%0d expected=0", writeAddress); end
    total++; if (bus.readData !== 16'd0) begin bad++; $display("FAIL rstpost_readdata actual=%0d expected=0", bus.readData); end
    step();
    adcReset = 1'b0;
    step();
    $display("test_reset_mid_post: asynchronous reset checked");
  endtask

  task automatic test_prefill_trigger();
    arm(4);
    sendBeat(0);
    triggerIn = 1'b1;
    sendBeat(1);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL prefill_ignore actual=%0d expected=1", state); end
    triggerIn = 1'b0;
    sendBeat(2);
    sendBeat(3);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL prefill_to_armed actual=%0d expected=2", state); end
    triggerIn = 1'b1;
    step();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL armed_edge actual=%0d expected=3", state); end
    total++; if (triggerAddress !== 5'd4) begin bad++; $display("FAIL armed_trigaddr actual=%0d expected=4", triggerAddress); end
    triggerIn = 1'b0;
    abortStrobe = 1'b1;
    step();
    abortStrobe = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL abort_idle actual=%0d expected=0", state); end
    $display("test_prefill_trigger: prefill edge ignored, armed edge honoured");
  endtask

  task automatic test_wraparound();
    logic [15:0] v;
    arm(0);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL wrap_armed actual=%0d expected=2", state); end
    for (int k = 0; k < 100; k++) sendBeat(k);
    force_trig();
    total++; if (triggerAddress !== 5'd4) begin bad++; $display("FAIL wrap_trigaddr actual=%0d expected=4", triggerAddress); end
    for (int k = 100; k < 132; k++) sendBeat(k);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL wrap_done actual=%0d expected=4", state); end
    readSample(0, 0, v);
    total++; if (v !== expSample(100, 0)) begin bad++; $display("FAIL wrap_rd0 actual=%0d expected=%0d", v, expSample(100, 0)); end
    readSample(27, 1, v);
    total++; if (v !== expSample(127, 1)) begin bad++; $display("FAIL wrap_rd27 actual=%0d expected=%0d", v, expSample(127, 1)); end
    readSample(28, 2, v);
    total++; if (v !== expSample(128, 2)) begin bad++; $display("FAIL wrap_rd28 actual=%0d expected=%0d", v, expSample(128, 2)); end
    readSample(31, 3, v);
    total++; if (v !== expSample(131, 3)) begin bad++; $display("FAIL wrap_rd31 actual=%0d expected=%0d", v, expSample(131, 3)); end
    $display("test_wraparound: record spans the ring wrap");
  endtask

  task automatic test_pre_zero();
    arm(0);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL pre0_armed actual=%0d expected=2", state); end
    for (int k = 0; k < 5; k++) sendBeat(k);
    force_trig();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL pre0_post actual=%0d expected=3", state); end
    total++; if (triggerAddress !== 5'd5) begin bad++; $display("FAIL pre0_trigaddr actual=%0d expected=5", triggerAddress); end
    $display("test_pre_zero: straight to ARMED, trigger latched");
  endtask

  task automatic test_valid_gaps();
    logic [15:0] v;
    for (int i = 0; i < 62; i++) begin
      if (i % 2 == 0) sendBeat(200 + i / 2);
      else step();
    end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL gaps_not_early actual=%0d expected=3", state); end
    sendBeat(231);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL gaps_done actual=%0d expected=4", state); end
    total++; if (writeAddress !== 5'd5) begin bad++; $display("FAIL gaps_wp actual=%0d expected=5", writeAddress); end
    readSample(0, 0, v);
    total++; if (v !== expSample(200, 0)) begin bad++; $display("FAIL gaps_rd0 actual=%0d expected=%0d", v, expSample(200, 0)); end
    readSample(10, 2, v);
    total++; if (v !== expSample(210, 2)) begin bad++; $display("FAIL gaps_rd10 actual=%0d expected=%0d", v, expSample(210, 2)); end
    readSample(31, 1, v);
    total++; if (v !== expSample(231, 1)) begin bad++; $display("FAIL gaps_rd31 actual=%0d expected=%0d", v, expSample(231, 1)); end
    $display("test_valid_gaps: 32 beats stored without holes");
  endtask

  task automatic test_abort_arm();
    logic [15:0] v;
    preTriggerWords = 5'd3;
    abortStrobe = 1'b1;
    armStrobe   = 1'b1;
    step();
    abortStrobe = 1'b0;
    armStrobe   = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL abortarm_idle actual=%0d expected=0", state); end
    total++; if (writeAddress !== 5'd5) begin bad++; $display("FAIL abortarm_wp actual=%0d expected=5", writeAddress); end
    for (int k = 300; k < 304; k++) sendBeat(k);
    total++; if (writeAddress !== 5'd5) begin bad++; $display("FAIL abortarm_nowrite actual=%0d expected=5", writeAddress); end
    readSample(0, 0, v);
    total++; if (v !== expSample(200, 0)) begin bad++; $display("FAIL abortarm_mem actual=%0d expected=%0d", v, expSample(200, 0)); end
    $display("test_abort_arm: abort wins, memory kept");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    adcReset        = 1'b1;
    triggerIn       = 1'b0;
    armStrobe       = 1'b0;
    abortStrobe     = 1'b0;
    forceTrigger    = 1'b0;
    preTriggerWords = '0;
    bus.axiValid    = 1'b0;
    bus.axiData     = '1;
    bus.readAddress = '0;
    bus.readSelect  = '0;
    test_reset();
    test_pre8();
    test_reset_mid_post();
    test_prefill_trigger();
    test_wraparound();
    test_pre_zero();
    test_valid_gaps();
    test_abort_arm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
